// File: rtl/load_store_unit.sv
// Load/store unit: turns a single-cycle core memory access into a valid/ready bus
// request plus response, with lane steering and load extension. Optional WAIT
// watchdog enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   input  logic            mem_write,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] rdata,
   output logic            stall,
   output logic            fault,
   output logic            bus_req_valid,
   input  logic            bus_req_ready,
   output logic            bus_we,
   output logic [31:0]     bus_addr,
   output logic [3:0]      bus_wstrb,
   output logic [31:0]     bus_wdata,
   input  logic            bus_rsp_valid,
   input  logic [31:0]     bus_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

   if (XLEN != 32) begin : g_bad_xlen
      $error("load_store_unit supports XLEN=32 only");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_e      state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] baddr_q, baddr_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;

   logic        illegal;
   logic [3:0]  st_wstrb;
   logic [31:0] st_wdata;
   logic        expire;

   // Sign/zero-extend the addressed byte or halfword out of the returned word.
   function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{off, 3'b000} +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b100:  return {24'b0, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b101:  return {16'b0, h};
         default: return w;
      endcase
   endfunction

   always_comb begin
      illegal = 1'b0;
      case (funct3)
         3'b000, 3'b100: illegal = 1'b0;
         3'b001, 3'b101: illegal = addr[0];
         3'b010:         illegal = (addr[1:0] != 2'b00);
         default:        illegal = 1'b1;
      endcase
      if (mem_write && funct3[2]) illegal = 1'b1;
   end

   always_comb begin
      st_wstrb = 4'b1111;
      st_wdata = wdata;
      case (funct3[1:0])
         2'b00: begin
            st_wstrb = 4'b0001 << addr[1:0];
            st_wdata = {4{wdata[7:0]}};
         end
         2'b01: begin
            st_wstrb = 4'b0011 << addr[1:0];
            st_wdata = {2{wdata[15:0]}};
         end
         default: begin
            st_wstrb = 4'b1111;
            st_wdata = wdata;
         end
      endcase
   end

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counter is held at zero outside WAIT so it always starts clean on entry.
   always_comb begin
      cnt_d  = '0;
      expire = 1'b0;
      if (state_q == WAIT && !bus_rsp_valid) begin
         cnt_d  = cnt_q + 1'b1;
         expire = (cnt_d == TO_LIMIT);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`else
   assign expire = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      off_d   = off_q;
      baddr_d = baddr_q;
      wstrb_d = wstrb_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      stall   = 1'b0;
      fault   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (illegal) begin
                  fault = 1'b1;
               end else begin
                  stall   = 1'b1;
                  we_d    = mem_write;
                  f3_d    = funct3;
                  off_d   = addr[1:0];
                  baddr_d = {addr[31:2], 2'b00};
                  wstrb_d = mem_write ? st_wstrb : 4'b0000;
                  wdata_d = mem_write ? st_wdata : 32'h0;
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            stall = 1'b1;
            if (bus_req_ready) state_d = WAIT;
         end
         WAIT: begin
            stall = 1'b1;
            if (bus_rsp_valid) begin
               if (!we_q) rdata_d = fmt_load(f3_q, off_q, bus_rdata);
               state_d = DONE;
            end else if (expire) begin
               fault = 1'b1;
               if (!we_q) rdata_d = 32'h0;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         off_q   <= 2'b00;
         baddr_q <= 32'h0;
         wstrb_q <= 4'b0000;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         baddr_q <= baddr_d;
         wstrb_q <= wstrb_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   assign bus_req_valid = (state_q == REQ);
   assign bus_we        = we_q;
   assign bus_addr      = baddr_q;
   assign bus_wstrb     = wstrb_q;
   assign bus_wdata     = wdata_q;
   assign rdata         = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vectors plus randomized accesses
// checked against a behavioural model of the access rules.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;
   logic        fault;
   logic        bus_req_valid;
   logic        bus_req_ready;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic        bus_rsp_valid;
   logic [31:0] bus_rdata;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_rdata = 32'h0;

   always #5 clk = ~clk;

   load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .mem_write(mem_write),
      .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
      .fault(fault), .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
      .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
      .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
   );

   // ---------------- reference model ----------------
   function automatic int unsigned size_m(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit legal_m(input bit we, input logic [2:0] f3, input logic [31:0] a);
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
      if (we && f3 >= 3'd4) return 1'b0;
      return (a % size_m(f3)) == 0;
   endfunction

   function automatic logic [3:0] strb_m(input bit we, input logic [2:0] f3, input logic [31:0] a);
      int unsigned v;
      if (!we) return 4'b0000;
      v = ((1 << size_m(f3)) - 1) << (a % 4);
      return v[3:0];
   endfunction

   function automatic logic [31:0] wdata_m(input logic [2:0] f3, input logic [31:0] wd);
      case (size_m(f3))
         1:       return {24'b0, wd[7:0]} * 32'h0101_0101;
         2:       return {16'b0, wd[15:0]} * 32'h0001_0001;
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] load_m(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] w);
      longint      v;
      int unsigned sz;
      sz = size_m(f3);
      v  = {32'b0, w >> (8 * (a % 4))};
      if (sz < 4) begin
         v = v % (64'd1 << (8 * sz));
         if (!f3[2] && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
      end
      return v[31:0];
   endfunction

   // ---------------- generic access driver ----------------
   task automatic do_access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int rdy_dly, input int rsp_dly,
                            input logic [31:0] word, input bit spurious,
                            output logic [3:0] seen_strb, output logic [31:0] seen_wdata);
      bit lg;
      int stalls;
      lg = legal_m(we, f3, a);
      stalls = 0;
      seen_strb = 4'b0;
      seen_wdata = 32'h0;
      @(posedge clk); #1;
      req_valid = 1'b1; mem_write = we; funct3 = f3; addr = a; wdata = wd;
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
      #1;
      checks++;
      if (stall !== lg) begin
         errors++; $display("FAIL idle_stall: got %b want %b (f3=%0d a=%h)", stall, lg, f3, a);
      end
      checks++;
      if (fault !== !lg) begin
         errors++; $display("FAIL idle_fault: got %b want %b (f3=%0d a=%h)", fault, !lg, f3, a);
      end
      if (stall === 1'b1) stalls++;
      if (!lg) begin
         @(posedge clk); #1;
         req_valid = 1'b0;
         #1;
         checks++;
         if (bus_req_valid !== 1'b0 || fault !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL illegal_after: req_valid=%b fault=%b stall=%b want 0 0 0",
                     bus_req_valid, fault, stall);
         end
         checks++;
         if (rdata !== exp_rdata) begin
            errors++; $display("FAIL illegal_rdata: got %h want %h", rdata, exp_rdata);
         end
         return;
      end
      for (int d = 0; d <= rdy_dly; d++) begin
         @(posedge clk); #1;
         bus_req_ready = (d == rdy_dly);
         bus_rsp_valid = spurious && ($urandom_range(1) == 1);
         bus_rdata = $urandom;
         #1;
         if (stall === 1'b1) stalls++;
         checks++;
         if (bus_req_valid !== 1'b1 || bus_we !== we || bus_addr !== (a & 32'hFFFF_FFFC) ||
             bus_wstrb !== strb_m(we, f3, a)) begin
            errors++;
            $display("FAIL req_fields: vld=%b we=%b addr=%h strb=%b want 1 %b %h %b",
                     bus_req_valid, bus_we, bus_addr, bus_wstrb, we, a & 32'hFFFF_FFFC,
                     strb_m(we, f3, a));
         end
         if (we) begin
            checks++;
            if (bus_wdata !== wdata_m(f3, wd)) begin
               errors++; $display("FAIL req_wdata: got %h want %h", bus_wdata, wdata_m(f3, wd));
            end
         end
         seen_strb = bus_wstrb;
         seen_wdata = bus_wdata;
      end
      for (int d = 0; d <= rsp_dly; d++) begin
         @(posedge clk); #1;
         bus_req_ready = 1'b0;
         bus_rsp_valid = (d == rsp_dly);
         bus_rdata = (d == rsp_dly) ? word : $urandom;
         #1;
         if (stall === 1'b1) stalls++;
         checks++;
         if (bus_req_valid !== 1'b0 || stall !== 1'b1) begin
            errors++;
            $display("FAIL wait_state: req_valid=%b stall=%b want 0 1", bus_req_valid, stall);
         end
      end
      @(posedge clk); #1;
      bus_rsp_valid = 1'b0;
      bus_rdata = $urandom;
      #1;
      if (!we) exp_rdata = load_m(f3, a, word);
      checks++;
      if (stall !== 1'b0 || fault !== 1'b0) begin
         errors++; $display("FAIL done_state: stall=%b fault=%b want 0 0", stall, fault);
      end
      checks++;
      if (rdata !== exp_rdata) begin
         errors++; $display("FAIL done_rdata: got %h want %h (f3=%0d a=%h)", rdata, exp_rdata, f3, a);
      end
      checks++;
      if (stalls != rdy_dly + rsp_dly + 3) begin
         errors++; $display("FAIL stall_cycles: got %0d want %0d", stalls, rdy_dly + rsp_dly + 3);
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         req_valid = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1; req_valid = 1'b0; mem_write = 1'b0; funct3 = 3'b0; addr = 32'h0;
      wdata = 32'h0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if ({stall, fault, bus_req_valid, bus_we} !== 4'b0000) begin
         errors++; $display("FAIL reset_ctrl: got %b want 0000", {stall, fault, bus_req_valid, bus_we});
      end
      checks++;
      if (rdata !== 32'h0 || bus_addr !== 32'h0 || bus_wstrb !== 4'h0 || bus_wdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: rdata=%h addr=%h strb=%b wdata=%h want all 0",
                  rdata, bus_addr, bus_wstrb, bus_wdata);
      end
      exp_rdata = 32'h0;
   endtask

   task automatic test_lw();
      logic [3:0] s; logic [31:0] w;
      do_access(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'h8899AABB, 1'b0, s, w);
      checks++;
      if (rdata !== 32'h8899AABB || s !== 4'b0000) begin
         errors++; $display("FAIL lw_vector: rdata=%h strb=%b want 8899aabb 0000", rdata, s);
      end
      idle_cycles(1);
   endtask

   task automatic test_lb();
      logic [3:0] s; logic [31:0] w;
      do_access(1'b0, 3'b000, 32'h203, 32'h0, 0, 1, 32'h80FF1234, 1'b0, s, w);
      checks++;
      if (rdata !== 32'hFFFFFF80) begin
         errors++; $display("FAIL lb_sign: got %h want ffffff80", rdata);
      end
      do_access(1'b0, 3'b100, 32'h203, 32'h0, 1, 0, 32'h80FF1234, 1'b0, s, w);
      checks++;
      if (rdata !== 32'h00000080) begin
         errors++; $display("FAIL lbu_zero: got %h want 00000080", rdata);
      end
      idle_cycles(1);
   endtask

   task automatic test_sh();
      logic [3:0] s; logic [31:0] w;
      do_access(1'b1, 3'b001, 32'h42, 32'h1234ABCD, 4, 0, 32'hFFFF_FFFF, 1'b0, s, w);
      checks++;
      if (s !== 4'b1100 || w !== 32'hABCDABCD) begin
         errors++; $display("FAIL sh_vector: strb=%b wdata=%h want 1100 abcdabcd", s, w);
      end
      checks++;
      if (rdata !== 32'h00000080) begin
         errors++; $display("FAIL sh_rdata_hold: got %h want 00000080", rdata);
      end
      idle_cycles(1);
   endtask

   task automatic test_illegal();
      logic [3:0] s; logic [31:0] w;
      do_access(1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0, 1'b0, s, w);
      do_access(1'b0, 3'b001, 32'h43, 32'h0, 0, 0, 32'h0, 1'b0, s, w);
      do_access(1'b1, 3'b100, 32'h40, 32'h55, 0, 0, 32'h0, 1'b0, s, w);
      do_access(1'b0, 3'b011, 32'h40, 32'h0, 0, 0, 32'h0, 1'b0, s, w);
      checks++;
      if (rdata !== 32'h00000080) begin
         errors++; $display("FAIL illegal_hold: got %h want 00000080", rdata);
      end
      idle_cycles(1);
   endtask

   task automatic test_reset_in_wait();
      @(posedge clk); #1;
      req_valid = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h100;
      @(posedge clk); #1;
      bus_req_ready = 1'b1;
      @(posedge clk); #1;
      bus_req_ready = 1'b0; req_valid = 1'b0; reset = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b1 || bus_req_valid !== 1'b0) begin
         errors++; $display("FAIL rst_wait_pre: stall=%b req_valid=%b want 1 0", stall, bus_req_valid);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0 || bus_req_valid !== 1'b0 || rdata !== 32'h0 || fault !== 1'b0) begin
         errors++;
         $display("FAIL rst_wait_post: stall=%b req_valid=%b rdata=%h fault=%b want 0 0 0 0",
                  stall, bus_req_valid, rdata, fault);
      end
      @(posedge clk); #1;
      bus_rsp_valid = 1'b1; bus_rdata = 32'hDEADBEEF;
      @(posedge clk); #1;
      bus_rsp_valid = 1'b0;
      #1;
      checks++;
      if (rdata !== 32'h0 || stall !== 1'b0) begin
         errors++; $display("FAIL rst_late_rsp: rdata=%h stall=%b want 0 0", rdata, stall);
      end
      exp_rdata = 32'h0;
   endtask

   task automatic test_back_to_back();
      logic [3:0]  s; logic [31:0] w;
      for (int i = 0; i < 60; i++) begin
         do_access($urandom_range(1) == 1, 3'($urandom_range(7)), $urandom, $urandom,
                   $urandom_range(3), $urandom_range(3), $urandom, 1'b1, s, w);
         if ($urandom_range(3) == 0) idle_cycles(1);
      end
      idle_cycles(1);
   endtask

`ifdef LSU_TIMEOUT_EN
   task automatic test_timeout();
      @(posedge clk); #1;
      req_valid = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h300;
      @(posedge clk); #1;
      bus_req_ready = 1'b1;
      @(posedge clk); #1;
      bus_req_ready = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (c > 1) begin
            @(posedge clk); #1;
         end
         #1;
         checks++;
         if (fault !== (c == 8) || stall !== 1'b1) begin
            errors++; $display("FAIL timeout_wait: cycle %0d fault=%b stall=%b want %b 1",
                               c, fault, stall, c == 8);
         end
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0 || fault !== 1'b0 || rdata !== 32'h0) begin
         errors++; $display("FAIL timeout_done: stall=%b fault=%b rdata=%h want 0 0 0",
                            stall, fault, rdata);
      end
      exp_rdata = 32'h0;
      idle_cycles(1);
   endtask
`endif

   initial begin
      test_reset();
      test_lw();
      test_lb();
      test_sh();
      test_illegal();
      test_reset_in_wait();
      test_back_to_back();
`ifdef LSU_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
